fir_out_checker: RTL and testbench

Synthesizable response checker for the output end of the fir block's streaming interface. It takes the same 4-bit sample stream that drives the fir, computes the golden convolution with programmable coefficients, and aligns it to the fir's 32-bit output by a fixed latency. It compares every aligned sample and keeps mismatch and compare counters plus a sticky fail flag. It sits beside the fir in benches, or on-chip as a BIST monitor.

---
 rtl/fir_out_checker_if.sv | 31 +++
 rtl/fir_out_checker.sv | 114 +++++++++++
 tb/tb_fir_out_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fir_out_checker_if.sv
// rtl/fir_out_checker_if.sv - stimulus, dut-output and result bundle for fir_out_checker
interface fir_out_checker_if #(
  parameter int TAPS   = 4,
  parameter int COEF_W = 8,
  parameter int CNT_W  = 16
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic              en;
  logic [3:0]        in;
  logic [31:0]       dut_out;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [31:0]       expected;
  logic              valid_cmp;
  logic              mismatch;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  cmp_count;
  logic              sticky_fail;

  modport master (
    output en, in, dut_out, coef_we, coef_addr, coef_data,
    input  expected, valid_cmp, mismatch, err_count, cmp_count, sticky_fail
  );

  modport slave (
    input  en, in, dut_out, coef_we, coef_addr, coef_data,
    output expected, valid_cmp, mismatch, err_count, cmp_count, sticky_fail
  );
endinterface

// File: rtl/fir_out_checker.sv
// rtl/fir_out_checker.sv - golden FIR model aligned to a fir output, with compare counters
module fir_out_checker #(
  parameter int TAPS   = 4,
  parameter int COEF_W = 8,
  parameter int LAT    = 1,
  parameter int CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  fir_out_checker_if.slave bus
);
  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int FW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK} state_e;

  state_e            state_q;
  logic [FW-1:0]     fill_q;
  logic [COEF_W-1:0] coef_q [TAPS];
  logic [3:0]        hist_q [TAPS];
  logic [3:0]        hist_d [TAPS];
  logic [31:0]       pipe_q [LAT];
  logic [31:0]       pipe_d [LAT];
  logic [31:0]       g_d;
  logic [31:0]       head;
  logic [31:0]       expected_q;
  logic              valid_q;
  logic              mismatch_q;
  logic              sticky_q;
  logic [CNT_W-1:0]  err_q;
  logic [CNT_W-1:0]  cmp_q;
  logic              cmp_en;

  // Golden value is formed from the history as it will look after this edge,
  // so pipe stage 0 holds g[n] right after s[n] is sampled.
  always_comb begin
    hist_d[0] = bus.in;
    for (int k = 1; k < TAPS; k++) hist_d[k] = hist_q[k-1];
    g_d = '0;
    for (int k = 0; k < TAPS; k++) g_d = g_d + 32'(coef_q[k]) * 32'(hist_d[k]);
    pipe_d[0] = g_d;
    for (int j = 1; j < LAT; j++) pipe_d[j] = pipe_q[j-1];
  end

  assign head   = pipe_q[LAT-1];
  assign cmp_en = bus.en && ((state_q == S_CHECK) ||
                             ((state_q == S_FILL) && (fill_q == FILL_LAST)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fill_q     <= '0;
      expected_q <= '0;
      valid_q    <= 1'b0;
      mismatch_q <= 1'b0;
      sticky_q   <= 1'b0;
      err_q      <= '0;
      cmp_q      <= '0;
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= '0;
        hist_q[k] <= '0;
      end
      for (int j = 0; j < LAT; j++) pipe_q[j] <= '0;
    end else begin
      valid_q    <= cmp_en;
      mismatch_q <= cmp_en && (bus.dut_out != head);
      if (cmp_en) begin
        expected_q <= head;
        if (cmp_q != '1) cmp_q <= cmp_q + CNT_W'(1);
        if (bus.dut_out != head) begin
          sticky_q <= 1'b1;
          if (err_q != '1) err_q <= err_q + CNT_W'(1);
        end
      end

      // Dropping en anywhere flushes the run so a restart sees zero-filled samples.
      if (bus.en) begin
        hist_q <= hist_d;
        pipe_q <= pipe_d;
      end else begin
        for (int k = 0; k < TAPS; k++) hist_q[k] <= '0;
        for (int j = 0; j < LAT; j++) pipe_q[j] <= '0;
      end

      case (state_q)
        S_IDLE: begin
          fill_q <= '0;
          if (bus.coef_we) begin
            for (int k = 0; k < TAPS; k++)
              if (bus.coef_addr == AW'(k)) coef_q[k] <= bus.coef_data;
          end
          if (bus.en) state_q <= S_FILL;
        end
        S_FILL: begin
          if (!bus.en) state_q <= S_IDLE;
          else if (fill_q == FILL_LAST) state_q <= S_CHECK;
          else fill_q <= fill_q + FW'(1);
        end
        S_CHECK: begin
          if (!bus.en) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.expected    = expected_q;
  assign bus.valid_cmp   = valid_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.err_count   = err_q;
  assign bus.cmp_count   = cmp_q;
  assign bus.sticky_fail = sticky_q;
endmodule

// File: tb/tb_fir_out_checker.sv
// tb/tb_fir_out_checker.sv - directed-vector bench for fir_out_checker
module tb_fir_out_checker;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   in_v[$];
  int   gold_v[$];

  always #5 clk = ~clk;

  fir_out_checker_if #(.TAPS(4), .COEF_W(8), .CNT_W(16)) ifa ();
  fir_out_checker_if #(.TAPS(4), .COEF_W(8), .CNT_W(16)) ifb ();
  fir_out_checker_if #(.TAPS(4), .COEF_W(8), .CNT_W(4))  ifc ();

  fir_out_checker #(.TAPS(4), .COEF_W(8), .LAT(1), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  fir_out_checker #(.TAPS(4), .COEF_W(8), .LAT(3), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  fir_out_checker #(.TAPS(4), .COEF_W(8), .LAT(1), .CNT_W(4))  u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c = '{c0, c1, c2, c3};
    for (int k = 0; k < 4; k++) begin
      ifa.coef_we = 1'b1; ifa.coef_addr = 2'(k); ifa.coef_data = 8'(c[k]);
      tick();
    end
    ifa.coef_we = 1'b0;
  endtask

  // n compares on LAT=1 instance; dut_out mirrors gold except at bad_idx (driven 5).
  task automatic run_a(input int n, input int bad_idx, input bit wr_mid);
    for (int i = 0; i <= n; i++) begin
      ifa.en      = 1'b1;
      ifa.in      = 4'(in_v[i]);
      ifa.dut_out = (i == 0) ? 32'd0 : ((i - 1 == bad_idx) ? 32'd5 : 32'(gold_v[i-1]));
      ifa.coef_we = wr_mid && (i == 1);
      ifa.coef_addr = 2'd0;
      ifa.coef_data = 8'd9;
      tick();
      ifa.coef_we = 1'b0;
      if (i == 0) chk("a_first_edge_valid", 32'(ifa.valid_cmp), 32'd0);
      else begin
        chk("a_valid", 32'(ifa.valid_cmp), 32'd1);
        chk("a_expected", ifa.expected, 32'(gold_v[i-1]));
        chk("a_mismatch", 32'(ifa.mismatch), 32'(i - 1 == bad_idx));
      end
    end
    ifa.en = 1'b0;
    tick();
    chk("a_idle_valid", 32'(ifa.valid_cmp), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ifa.en = 0; ifa.in = 0; ifa.dut_out = 0; ifa.coef_we = 0; ifa.coef_addr = 0; ifa.coef_data = 0;
    ifb.en = 0; ifb.in = 0; ifb.dut_out = 0; ifb.coef_we = 0; ifb.coef_addr = 0; ifb.coef_data = 0;
    ifc.en = 0; ifc.in = 0; ifc.dut_out = 0; ifc.coef_we = 0; ifc.coef_addr = 0; ifc.coef_data = 0;
    tick(); tick();
    chk("rst_expected", ifa.expected, 32'd0);
    chk("rst_valid", 32'(ifa.valid_cmp), 32'd0);
    chk("rst_err", 32'(ifa.err_count), 32'd0);
    chk("rst_cmp", 32'(ifa.cmp_count), 32'd0);
    chk("rst_sticky", 32'(ifa.sticky_fail), 32'd0);
    rst = 1'b0;

    // Impulse
    load_a(1, 2, 3, 4);
    in_v = '{1, 0, 0, 0, 0, 0};
    gold_v = '{1, 2, 3, 4, 0};
    run_a(5, -1, 1'b0);
    chk("imp_cmp", 32'(ifa.cmp_count), 32'd5);
    chk("imp_err", 32'(ifa.err_count), 32'd0);
    chk("imp_sticky", 32'(ifa.sticky_fail), 32'd0);

    // Partial run with a coef write mid-CHECK, then fresh restart
    run_a(2, -1, 1'b1);
    chk("drop_cmp_held", 32'(ifa.cmp_count), 32'd7);
    chk("drop_expected_held", ifa.expected, 32'd2);
    run_a(5, -1, 1'b0);
    chk("restart_cmp", 32'(ifa.cmp_count), 32'd12);

    // Fault injection
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_cmp", 32'(ifa.cmp_count), 32'd0);
    load_a(1, 2, 3, 4);
    run_a(5, 2, 1'b0);
    chk("fault_err", 32'(ifa.err_count), 32'd1);
    chk("fault_sticky", 32'(ifa.sticky_fail), 32'd1);
    run_a(5, -1, 1'b0);
    chk("fault_err_kept", 32'(ifa.err_count), 32'd1);
    chk("fault_sticky_kept", 32'(ifa.sticky_fail), 32'd1);
    chk("fault_cmp", 32'(ifa.cmp_count), 32'd10);

    // Step with full-scale coefs; 16 truncates to 0 on the 4-bit input
    rst = 1'b1; tick(); rst = 1'b0;
    load_a(255, 255, 255, 255);
    in_v = '{15, 15, 15, 15, 15, 16, 16, 16};
    gold_v = '{3825, 7650, 11475, 15300, 15300, 11475, 7650};
    run_a(7, -1, 1'b0);
    chk("step_err", 32'(ifa.err_count), 32'd0);

    // LAT=3
    begin
      int bin[9];
      int bgold[6];
      bin = '{3, 1, 0, 0, 0, 0, 0, 0, 0};
      bgold = '{3, 7, 11, 15, 4, 0};
      for (int k = 0; k < 4; k++) begin
        ifb.coef_we = 1'b1; ifb.coef_addr = 2'(k); ifb.coef_data = 8'(k + 1);
        tick();
      end
      ifb.coef_we = 1'b0;
      for (int i = 0; i < 9; i++) begin
        ifb.en = 1'b1;
        ifb.in = 4'(bin[i]);
        ifb.dut_out = (i >= 3) ? 32'(bgold[i-3]) : 32'd0;
        tick();
        if (i < 3) chk("lat3_no_valid", 32'(ifb.valid_cmp), 32'd0);
        else begin
          chk("lat3_valid", 32'(ifb.valid_cmp), 32'd1);
          chk("lat3_expected", ifb.expected, 32'(bgold[i-3]));
          chk("lat3_mismatch", 32'(ifb.mismatch), 32'd0);
        end
      end
      ifb.en = 1'b0;
      tick();
      chk("lat3_cmp", 32'(ifb.cmp_count), 32'd6);
      chk("lat3_err", 32'(ifb.err_count), 32'd0);
    end

    // Saturation: coefs 0, dut_out 1 -> every compare fails
    ifc.in = 4'd5;
    ifc.dut_out = 32'd1;
    ifc.en = 1'b1;
    for (int i = 0; i <= 20; i++) tick();
    chk("sat_err", 32'(ifc.err_count), 32'd15);
    chk("sat_cmp", 32'(ifc.cmp_count), 32'd15);
    chk("sat_sticky", 32'(ifc.sticky_fail), 32'd1);
    chk("sat_mismatch", 32'(ifc.mismatch), 32'd1);

    // Reset mid-CHECK
    rst = 1'b1;
    tick();
    chk("midrst_valid", 32'(ifc.valid_cmp), 32'd0);
    chk("midrst_mismatch", 32'(ifc.mismatch), 32'd0);
    chk("midrst_err", 32'(ifc.err_count), 32'd0);
    chk("midrst_cmp", 32'(ifc.cmp_count), 32'd0);
    chk("midrst_sticky", 32'(ifc.sticky_fail), 32'd0);
    rst = 1'b0;
    ifc.en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
